// File: rtl/dino_score_pkg.sv
// dino_score_pkg
//   Shared constants and encodings for the score sequencing logic.
//   - game_state_t : encoding seen by the renderer on game_state
//   - seq_state_t  : internal sequencer state; the low two bits equal the
//                    renderer encoding, so PAUSED reads back as 3 like OVER
//   - SCORE_DIGITS / SCORE_W : width of the packed BCD score
//   - DEF_TICK_DIV / DEF_DEAD_FRAMES : default timing constants
package dino_score_pkg;

    localparam int SCORE_DIGITS    = 5;
    localparam int SCORE_W         = 4 * SCORE_DIGITS;
    localparam int DEF_TICK_DIV    = 6;
    localparam int DEF_DEAD_FRAMES = 30;

    typedef enum logic [1:0] {
        GS_IDLE = 2'd0,
        GS_RUN  = 2'd1,
        GS_DEAD = 2'd2,
        GS_OVER = 2'd3
    } game_state_t;

    // Bit 2 only distinguishes PAUSED from OVER inside the sequencer.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_RUN    = 3'b001,
        ST_DEAD   = 3'b010,
        ST_OVER   = 3'b011,
        ST_PAUSED = 3'b111
    } seq_state_t;

endpackage

// File: rtl/score_sequencer_frame_divider.sv
// frame_divider
//   Counts tick_in pulses while en is high and flags every DIV-th one.
//   The count is held while en is low and cleared by clr.
//   Ports:
//     clk      in  system clock
//     rst_n    in  synchronous active-low reset
//     clr      in  clear the count to 0 (has priority over counting)
//     en       in  count enable
//     tick_in  in  pulse to be divided
//     tick_out out combinational: high on the tick_in that completes DIV counts
module frame_divider #(
    parameter int DIV = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    input  logic tick_in,
    output logic tick_out
);

    localparam int CW = 4;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap     = (cnt == LAST);
    assign tick_out = en & tick_in & wrap;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && tick_in) begin
            cnt <= wrap ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/score_sequencer.sv
// score_sequencer
//   Game-level controller for the BCD score counter: owns the game state,
//   drives the counter's start/frozen/tick controls, divides the frame tick
//   down to the score rate and latches the best score since reset.
//   Optional feature: define SCORE_PAUSE_EN to add pause_btn and a PAUSED
//   state (reported on game_state as 3, same as OVER).
//   Ports:
//     clk          in   system clock
//     rst_n        in   synchronous active-low reset
//     frame_tick   in   1-cycle end-of-frame pulse
//     start_btn    in   synchronised start/jump button, level
//     collision    in   1-cycle pulse, dino hit an obstacle
//     pause_btn    in   pause button, level (SCORE_PAUSE_EN only)
//     score_bcd    in   current counter value, 5 packed BCD digits
//     score_start  out  1-cycle clear pulse to the counter
//     score_frozen out  freeze level to the counter
//     score_tick   out  1-cycle increment pulse to the counter
//     hi_score     out  best score since reset, BCD
//     new_hi       out  last finished game set a new high score
//     game_state   out  0 IDLE, 1 RUN, 2 DEAD, 3 OVER/PAUSED
//   Every output comes straight from a flop.
module score_sequencer
    import dino_score_pkg::*;
#(
    parameter int TICK_DIV    = DEF_TICK_DIV,
    parameter int DEAD_FRAMES = DEF_DEAD_FRAMES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic               collision,
`ifdef SCORE_PAUSE_EN
    input  logic               pause_btn,
`endif
    input  logic [SCORE_W-1:0] score_bcd,
    output logic               score_start,
    output logic               score_frozen,
    output logic               score_tick,
    output logic [SCORE_W-1:0] hi_score,
    output logic               new_hi,
    output logic [1:0]         game_state
);

    localparam logic [5:0] DEAD_LAST = 6'(DEAD_FRAMES - 1);

    seq_state_t         state_q, state_d;
    logic               btn_q;
    logic               rise;
    logic               pause_rise;
    logic [5:0]         dead_cnt_q, dead_cnt_d;
    logic [SCORE_W-1:0] hi_d;
    logic               new_hi_d;
    logic               start_d;
    logic               div_clr, div_en, div_tick;

    assign rise       = start_btn & ~btn_q;
    assign game_state = state_q[1:0];

`ifdef SCORE_PAUSE_EN
    logic pause_q;
    assign pause_rise = pause_btn & ~pause_q;

    always_ff @(posedge clk) begin
        if (!rst_n) pause_q <= 1'b0;
        else        pause_q <= pause_btn;
    end
`else
    assign pause_rise = 1'b0;
`endif

    frame_divider #(.DIV(TICK_DIV)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (div_clr),
        .en       (div_en),
        .tick_in  (frame_tick),
        .tick_out (div_tick)
    );

    always_comb begin
        state_d    = state_q;
        dead_cnt_d = dead_cnt_q;
        hi_d       = hi_score;
        new_hi_d   = new_hi;
        start_d    = 1'b0;
        div_clr    = 1'b0;
        div_en     = 1'b0;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (rise) begin
                    state_d  = ST_RUN;
                    start_d  = 1'b1;
                    div_clr  = 1'b1;
                    new_hi_d = 1'b0;
                end
            end
            ST_RUN: begin
                // Collision outranks both a pause request and a frame tick,
                // so a dying frame never scores.
                if (collision) begin
                    state_d    = ST_DEAD;
                    dead_cnt_d = '0;
                    if (score_bcd > hi_score) begin
                        hi_d     = score_bcd;
                        new_hi_d = 1'b1;
                    end
                end else if (pause_rise) begin
                    state_d = ST_PAUSED;
                end else begin
                    div_en = 1'b1;
                end
            end
            ST_DEAD: begin
                if (frame_tick) begin
                    if (dead_cnt_q == DEAD_LAST) begin
                        state_d    = ST_OVER;
                        dead_cnt_d = '0;
                    end else begin
                        dead_cnt_d = dead_cnt_q + 6'd1;
                    end
                end
            end
            ST_PAUSED: begin
                // Divider is simply not enabled here, so it resumes where it stopped.
                if (pause_rise) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            btn_q        <= 1'b0;
            dead_cnt_q   <= '0;
            score_start  <= 1'b0;
            score_frozen <= 1'b1;
            score_tick   <= 1'b0;
            hi_score     <= '0;
            new_hi       <= 1'b0;
        end else begin
            state_q      <= state_d;
            btn_q        <= start_btn;
            dead_cnt_q   <= dead_cnt_d;
            score_start  <= start_d;
            score_frozen <= (state_d != ST_RUN);
            score_tick   <= div_tick;
            hi_score     <= hi_d;
            new_hi       <= new_hi_d;
        end
    end

endmodule

// File: tb/tb_score_sequencer.sv
// tb_score_sequencer
//   Self-checking bench for score_sequencer. Directed scenarios compare
//   against values stated by the game rules; a free-running reference model
//   (game mode, total frames scored, dead frames seen) tracks every output
//   for the randomized run. Define SCORE_PAUSE_EN to exercise the pause feature.
module tb_score_sequencer;
    import dino_score_pkg::*;

    localparam int TD = 6;
    localparam int DF = 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start_btn = 1'b0;
    logic        collision = 1'b0;
    logic [19:0] score_bcd = '0;
`ifdef SCORE_PAUSE_EN
    logic        pause_btn = 1'b0;
`endif
    logic        score_start, score_frozen, score_tick, new_hi;
    logic [19:0] hi_score;
    logic [1:0]  game_state;

    int n_cmp = 0;
    int n_bad = 0;

    score_sequencer #(.TICK_DIV(TD), .DEAD_FRAMES(DF)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_tick   (frame_tick),
        .start_btn    (start_btn),
        .collision    (collision),
`ifdef SCORE_PAUSE_EN
        .pause_btn    (pause_btn),
`endif
        .score_bcd    (score_bcd),
        .score_start  (score_start),
        .score_frozen (score_frozen),
        .score_tick   (score_tick),
        .hi_score     (hi_score),
        .new_hi       (new_hi),
        .game_state   (game_state)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // mode: 0 idle, 1 run, 2 dead, 3 over, 4 paused
    int          m_mode = 0;
    int          m_frames = 0;
    int          m_dead = 0;
    bit          m_btn_prev = 1'b0;
    bit          m_pause_prev = 1'b0;
    logic [19:0] m_hi = '0;
    bit          m_new_hi = 1'b0;
    bit          m_start = 1'b0;
    bit          m_tick = 1'b0;
    wire         m_rise = start_btn && !m_btn_prev;
`ifdef SCORE_PAUSE_EN
    wire         m_prise = pause_btn && !m_pause_prev;
`else
    wire         m_prise = 1'b0;
`endif

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode <= 0; m_frames <= 0; m_dead <= 0;
            m_btn_prev <= 1'b0; m_pause_prev <= 1'b0;
            m_hi <= '0; m_new_hi <= 1'b0; m_start <= 1'b0; m_tick <= 1'b0;
        end else begin
            m_btn_prev <= start_btn;
`ifdef SCORE_PAUSE_EN
            m_pause_prev <= pause_btn;
`endif
            m_start <= 1'b0;
            m_tick  <= 1'b0;
            case (m_mode)
                0, 3: if (m_rise) begin
                    m_mode <= 1; m_start <= 1'b1; m_frames <= 0; m_new_hi <= 1'b0;
                end
                1: begin
                    if (collision) begin
                        m_mode <= 2; m_dead <= 0;
                        if (score_bcd > m_hi) begin m_hi <= score_bcd; m_new_hi <= 1'b1; end
                    end else if (m_prise) begin
                        m_mode <= 4;
                    end else if (frame_tick) begin
                        m_frames <= m_frames + 1;
                        if ((m_frames + 1) % TD == 0) m_tick <= 1'b1;
                    end
                end
                2: if (frame_tick) begin
                    if (m_dead + 1 == DF) m_mode <= 3;
                    m_dead <= m_dead + 1;
                end
                4: if (m_prise) m_mode <= 1;
                default: m_mode <= 0;
            endcase
        end
    end

    wire [1:0]  exp_gs  = (m_mode == 4) ? 2'd3 : 2'(m_mode);
    wire [25:0] exp_vec = {exp_gs, m_start, (m_mode != 1), m_tick, m_new_hi, m_hi};
    wire [25:0] obs_vec = {game_state, score_start, score_frozen, score_tick, new_hi, hi_score};

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1; step();
            frame_tick = 1'b0; step();
        end
    endtask

    task automatic press();
        start_btn = 1'b1; step();
        start_btn = 1'b0;
    endtask

    function automatic logic [19:0] rand_bcd();
        logic [19:0] r;
        r = '0;
        for (int d = 0; d < 5; d++) r[4*d +: 4] = 4'($urandom_range(0, 9));
        return r;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [25:0] want;
        want = {2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 20'h0};
        rst_n = 1'b0;
        step(); step();
        n_cmp++;
        if (obs_vec !== want) begin
            n_bad++; $display("FAIL reset_values: got %h want %h", obs_vec, want);
        end
        rst_n = 1'b1;
        step();
        n_cmp++;
        if (obs_vec !== want) begin
            n_bad++; $display("FAIL reset_idle_hold: got %h want %h", obs_vec, want);
        end
    endtask

    task automatic test_start_and_ticks();
        int pulses;
        bit want;
        press();
        n_cmp++;
        if (score_start !== 1'b1 || game_state !== 2'd1 || score_frozen !== 1'b0) begin
            n_bad++; $display("FAIL start_pulse: got start=%b state=%0d frozen=%b want 1 1 0",
                              score_start, game_state, score_frozen);
        end
        step();
        n_cmp++;
        if (score_start !== 1'b0) begin
            n_bad++; $display("FAIL start_one_cycle: got %b want 0", score_start);
        end
        pulses = 0;
        for (int i = 1; i <= 60; i++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                step();
                n_cmp++;
                if (score_tick !== 1'b0 || score_start !== 1'b0) begin
                    n_bad++; $display("FAIL tick_idle: got tick=%b start=%b want 0 0", score_tick, score_start);
                end
            end
            frame_tick = 1'b1; step(); frame_tick = 1'b0;
            want = (i % TD == 0);
            if (score_tick === 1'b1) pulses++;
            n_cmp++;
            if (score_tick !== want || obs_vec !== exp_vec) begin
                n_bad++; $display("FAIL tick_frame%0d: got tick=%b vec=%h want tick=%b vec=%h",
                                  i, score_tick, obs_vec, want, exp_vec);
            end
        end
        step();
        n_cmp++;
        if (pulses != 10) begin
            n_bad++; $display("FAIL tick_count: got %0d want 10", pulses);
        end
    endtask

    task automatic test_collision_on_tick();
        run_ticks(5);
        frame_tick = 1'b1; collision = 1'b1; score_bcd = 20'h00123;
        step();
        frame_tick = 1'b0; collision = 1'b0;
        n_cmp++;
        if (score_tick !== 1'b0 || game_state !== 2'd2 || score_frozen !== 1'b1) begin
            n_bad++; $display("FAIL collision_wins: got tick=%b state=%0d frozen=%b want 0 2 1",
                              score_tick, game_state, score_frozen);
        end
        n_cmp++;
        if (hi_score !== 20'h00123 || new_hi !== 1'b1) begin
            n_bad++; $display("FAIL first_hi: got hi=%h new=%b want 00123 1", hi_score, new_hi);
        end
    endtask

    task automatic test_dead_button();
        run_ticks(DF - 1);
        press();
        step();
        n_cmp++;
        if (game_state !== 2'd2 || score_start !== 1'b0) begin
            n_bad++; $display("FAIL dead_ignores_btn: got state=%0d start=%b want 2 0", game_state, score_start);
        end
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        n_cmp++;
        if (game_state !== 2'd3 || score_frozen !== 1'b1) begin
            n_bad++; $display("FAIL over_after_30: got state=%0d frozen=%b want 3 1", game_state, score_frozen);
        end
        press();
        n_cmp++;
        if (game_state !== 2'd1 || score_start !== 1'b1 || new_hi !== 1'b0) begin
            n_bad++; $display("FAIL restart: got state=%0d start=%b new=%b want 1 1 0",
                              game_state, score_start, new_hi);
        end
    endtask

    task automatic test_hi_score();
        logic [19:0] ends[2];
        ends[0] = 20'h00099;
        ends[1] = 20'h00123;
        for (int g = 0; g < 2; g++) begin
            run_ticks(3);
            collision = 1'b1; score_bcd = ends[g]; step(); collision = 1'b0;
            n_cmp++;
            if (hi_score !== 20'h00123 || new_hi !== 1'b0) begin
                n_bad++; $display("FAIL hi_keep%0d: got hi=%h new=%b want 00123 0", g, hi_score, new_hi);
            end
            run_ticks(DF);
            press();
        end
    endtask

    task automatic test_held_button();
        collision = 1'b1; step(); collision = 1'b0;
        run_ticks(DF);
        start_btn = 1'b1; step();
        n_cmp++;
        if (game_state !== 2'd1 || score_start !== 1'b1) begin
            n_bad++; $display("FAIL held_first_start: got state=%0d start=%b want 1 1", game_state, score_start);
        end
        run_ticks(2);
        collision = 1'b1; step(); collision = 1'b0;
        run_ticks(DF);
        for (int i = 0; i < 4; i++) begin
            step();
            n_cmp++;
            if (game_state !== 2'd3 || score_start !== 1'b0) begin
                n_bad++; $display("FAIL held_no_restart: got state=%0d start=%b want 3 0", game_state, score_start);
            end
        end
        start_btn = 1'b0; step();
        press();
        n_cmp++;
        if (game_state !== 2'd1 || score_start !== 1'b1) begin
            n_bad++; $display("FAIL held_repress: got state=%0d start=%b want 1 1", game_state, score_start);
        end
    endtask

    task automatic test_reset_mid_run();
        run_ticks(2);
        collision = 1'b1; score_bcd = 20'h00500; step(); collision = 1'b0;
        run_ticks(DF);
        press();
        run_ticks(4);
        n_cmp++;
        if (hi_score !== 20'h00500 || game_state !== 2'd1) begin
            n_bad++; $display("FAIL pre_reset: got hi=%h state=%0d want 00500 1", hi_score, game_state);
        end
        rst_n = 1'b0; step(); rst_n = 1'b1;
        n_cmp++;
        if (game_state !== 2'd0 || hi_score !== 20'h0 || score_frozen !== 1'b1 || new_hi !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset: got state=%0d hi=%h frozen=%b new=%b want 0 00000 1 0",
                              game_state, hi_score, score_frozen, new_hi);
        end
    endtask

`ifdef SCORE_PAUSE_EN
    task automatic test_pause();
        int pulses;
        step();
        press();
        run_ticks(3);
        pause_btn = 1'b1; step(); pause_btn = 1'b0;
        n_cmp++;
        if (game_state !== 2'd3 || score_frozen !== 1'b1) begin
            n_bad++; $display("FAIL pause_enter: got state=%0d frozen=%b want 3 1", game_state, score_frozen);
        end
        run_ticks(4);
        collision = 1'b1; step(); collision = 1'b0;
        pause_btn = 1'b1; step(); pause_btn = 1'b0;
        n_cmp++;
        if (game_state !== 2'd1 || score_start !== 1'b0 || score_frozen !== 1'b0) begin
            n_bad++; $display("FAIL pause_resume: got state=%0d start=%b frozen=%b want 1 0 0",
                              game_state, score_start, score_frozen);
        end
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            frame_tick = 1'b1; step(); frame_tick = 1'b0;
            if (score_tick === 1'b1) pulses++;
            step();
        end
        n_cmp++;
        if (pulses != 1) begin
            n_bad++; $display("FAIL pause_divider_held: got %0d want 1", pulses);
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 4000; c++) begin
            frame_tick = ($urandom_range(0, 2) == 0);
            collision  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 5) == 0) start_btn = ~start_btn;
`ifdef SCORE_PAUSE_EN
            if ($urandom_range(0, 29) == 0) pause_btn = ~pause_btn;
`endif
            score_bcd = rand_bcd();
            rst_n = ($urandom_range(0, 1999) != 0);
            step();
            n_cmp++;
            if (obs_vec !== exp_vec) begin
                n_bad++; $display("FAIL random_c%0d: got %h want %h", c, obs_vec, exp_vec);
            end
        end
        rst_n = 1'b1; frame_tick = 1'b0; collision = 1'b0; start_btn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start_and_ticks();
        test_collision_on_tick();
        test_dead_button();
        test_hi_score();
        test_held_button();
        test_reset_mid_run();
`ifdef SCORE_PAUSE_EN
        test_pause();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
